// File: rtl/vip_pkg.sv
// ============================================================================
//  Module   : vip_pkg
//  Brief    : Shared constants and types for the video-processing (vip) stages.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vip_pkg;

    localparam int VIP_H_ACTIVE = 640;
    localparam int VIP_V_ACTIVE = 480;
    localparam int VIP_CNT_W    = 20;
    localparam int VIP_CRD_W    = 11;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/vip_sync_edge.sv
// ============================================================================
//  Module   : vip_sync_edge
//  Brief    : Registers vsync/href and derives start-of-frame / end-of-line pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vip_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    input  logic href_i,
    output logic sof_o,
    output logic eol_o
);

    logic vsync_q;
    logic href_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
        end
    end

    assign sof_o = vsync_i & ~vsync_q;
    assign eol_o = ~href_i & href_q;

endmodule

`default_nettype wire

// File: rtl/edge_frame_stats.sv
// ============================================================================
//  Module   : edge_frame_stats
//  Brief    : Per-frame edge-pixel count and bounding box, published at next SOF.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_frame_stats
    import vip_pkg::*;
#(
    parameter int H_ACTIVE = VIP_H_ACTIVE,
    parameter int V_ACTIVE = VIP_V_ACTIVE,
    parameter int CNT_W    = VIP_CNT_W,
    parameter int CRD_W    = VIP_CRD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic             in_bit,
    output logic             stat_valid,
    output logic [CNT_W-1:0] stat_cnt,
    output logic             stat_hit,
    output logic [CRD_W-1:0] stat_xmin,
    output logic [CRD_W-1:0] stat_xmax,
    output logic [CRD_W-1:0] stat_ymin,
    output logic [CRD_W-1:0] stat_ymax,
    output logic             stat_err,
    output logic [15:0]      frame_cnt
);

    localparam logic [CRD_W-1:0] C_H_LIM = CRD_W'(H_ACTIVE);
    localparam logic [CRD_W-1:0] C_V_LIM = CRD_W'(V_ACTIVE);

    logic w_sof;
    logic w_eol;
    logic w_pix;
    logic w_in_range;
    logic w_acc_en;
    logic w_publish;
    logic w_clear;

    frame_state_e state_q, state_d;

    logic [CRD_W-1:0] x_q, y_q;
    logic             line_pix_q;

    logic [CNT_W-1:0] cnt_q;
    logic             hit_q, err_q;
    logic [CRD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;

    logic             stat_valid_q, stat_hit_q, stat_err_q;
    logic [CNT_W-1:0] stat_cnt_q;
    logic [CRD_W-1:0] stat_xmin_q, stat_xmax_q, stat_ymin_q, stat_ymax_q;
    logic [15:0]      frame_cnt_q;

    vip_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync_i (in_vsync),
        .href_i  (in_href),
        .sof_o   (w_sof),
        .eol_o   (w_eol)
    );

    assign w_pix      = in_clken & in_href & ~in_vsync;
    assign w_in_range = (x_q < C_H_LIM) && (y_q < C_V_LIM);
    assign w_acc_en   = (state_q == ACTIVE) && w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_SOF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        w_publish = 1'b0;
        w_clear   = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (w_sof) begin
                    w_clear = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_sof) begin
                    w_publish = 1'b1;
                    w_clear   = 1'b1;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // Position tracking; y only advances past lines that actually carried pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            line_pix_q <= 1'b0;
        end else if (w_sof) begin
            x_q        <= '0;
            y_q        <= '0;
            line_pix_q <= 1'b0;
        end else if (w_eol) begin
            x_q        <= '0;
            line_pix_q <= 1'b0;
            if (line_pix_q && (y_q != '1)) y_q <= y_q + CRD_W'(1);
        end else if (w_pix) begin
            line_pix_q <= 1'b1;
            if (x_q != '1) x_q <= x_q + CRD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
            xmin_q <= '1;
            xmax_q <= '0;
            ymin_q <= '1;
            ymax_q <= '0;
        end else if (w_clear) begin
            cnt_q  <= '0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
            xmin_q <= '1;
            xmax_q <= '0;
            ymin_q <= '1;
            ymax_q <= '0;
        end else if (w_acc_en) begin
            if (!w_in_range) begin
                err_q <= 1'b1;
            end else if (in_bit) begin
                hit_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                if (x_q < xmin_q) xmin_q <= x_q;
                if (x_q > xmax_q) xmax_q <= x_q;
                if (y_q < ymin_q) ymin_q <= y_q;
                if (y_q > ymax_q) ymax_q <= y_q;
            end
        end
    end

    // An edge-free frame reports a zero box rather than the all-ones min init.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_valid_q <= 1'b0;
            stat_cnt_q   <= '0;
            stat_hit_q   <= 1'b0;
            stat_err_q   <= 1'b0;
            stat_xmin_q  <= '0;
            stat_xmax_q  <= '0;
            stat_ymin_q  <= '0;
            stat_ymax_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            stat_valid_q <= w_publish;
            if (w_publish) begin
                stat_cnt_q  <= cnt_q;
                stat_hit_q  <= hit_q;
                stat_err_q  <= err_q;
                stat_xmin_q <= hit_q ? xmin_q : '0;
                stat_xmax_q <= hit_q ? xmax_q : '0;
                stat_ymin_q <= hit_q ? ymin_q : '0;
                stat_ymax_q <= hit_q ? ymax_q : '0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign stat_valid = stat_valid_q;
    assign stat_cnt   = stat_cnt_q;
    assign stat_hit   = stat_hit_q;
    assign stat_err   = stat_err_q;
    assign stat_xmin  = stat_xmin_q;
    assign stat_xmax  = stat_xmax_q;
    assign stat_ymin  = stat_ymin_q;
    assign stat_ymax  = stat_ymax_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_frame_stats.sv
// ============================================================================
//  Module   : tb_edge_frame_stats
//  Brief    : Directed scoreboard bench for edge_frame_stats (reduced 64x48 geometry).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_frame_stats;

    localparam int H  = 64;
    localparam int V  = 48;
    localparam int CW = 11;
    localparam int RW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vsync, in_href, in_clken, in_bit;
    logic          stat_valid, stat_hit, stat_err;
    logic [CW-1:0] stat_cnt;
    logic [RW-1:0] stat_xmin, stat_xmax, stat_ymin, stat_ymax;
    logic [15:0]   frame_cnt;

    edge_frame_stats #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CNT_W    (CW),
        .CRD_W    (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vsync   (in_vsync),
        .in_href    (in_href),
        .in_clken   (in_clken),
        .in_bit     (in_bit),
        .stat_valid (stat_valid),
        .stat_cnt   (stat_cnt),
        .stat_hit   (stat_hit),
        .stat_xmin  (stat_xmin),
        .stat_xmax  (stat_xmax),
        .stat_ymin  (stat_ymin),
        .stat_ymax  (stat_ymax),
        .stat_err   (stat_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt, hit, xmin, xmax, ymin, ymax, err, fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    bit   m_active;
    int   m_frames;
    int   m_cnt, m_hit, m_err, m_xmin, m_xmax, m_ymin, m_ymax;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_hit  = 0;
        m_err  = 0;
        m_xmin = (1 << RW) - 1;
        m_xmax = 0;
        m_ymin = (1 << RW) - 1;
        m_ymax = 0;
    endtask

    task automatic model_pix(input int x, input int y, input logic b);
        if (!m_active) return;
        if (x >= H || y >= V) begin
            m_err = 1;
        end else if (b) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_hit = 1;
            if (x < m_xmin) m_xmin = x;
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
        end
    endtask

    task automatic model_sof();
        exp_t e;
        if (m_active) begin
            m_frames = (m_frames + 1) & 16'hFFFF;
            e.cnt  = m_cnt;
            e.hit  = m_hit;
            e.err  = m_err;
            e.xmin = m_hit ? m_xmin : 0;
            e.xmax = m_hit ? m_xmax : 0;
            e.ymin = m_hit ? m_ymin : 0;
            e.ymax = m_hit ? m_ymax : 0;
            e.fc   = m_frames;
            q.push_back(e);
        end
        model_clear();
        m_active = 1'b1;
    endtask

    // y is the bench's own line index; each driven line carries at least one pixel.
    task automatic drive_line(input int y, input int npix, input bit gap, input bit ones, input int hx);
        for (int p = 0; p < npix; p++) begin
            in_href  = 1'b1;
            in_clken = 1'b1;
            in_bit   = ones || (p == hx);
            model_pix(p, y, in_bit);
            @(posedge clk) #1;
            if (gap) begin
                in_clken = 1'b0;
                in_bit   = 1'b1;
                @(posedge clk) #1;
            end
        end
        in_href  = 1'b0;
        in_clken = 1'b0;
        in_bit   = 1'b0;
        repeat (3) @(posedge clk) #1;
    endtask

    task automatic do_sof(input bit vpix);
        logic exp_pub;
        exp_pub  = m_active;
        in_vsync = 1'b1;
        in_href  = vpix;
        in_clken = vpix;
        in_bit   = vpix;
        model_sof();
        @(negedge clk);
        chk("valid_before_edge", 32'(stat_valid), 32'd0);
        @(negedge clk);
        chk("valid_latency", 32'(stat_valid), 32'(exp_pub));
        @(posedge clk) #1;
        in_href  = 1'b0;
        in_clken = 1'b0;
        in_bit   = 1'b0;
        repeat (2) @(posedge clk) #1;
        in_vsync = 1'b0;
        repeat (2) @(posedge clk) #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(stat_valid), 32'd0);
        chk({tag, "_cnt"},   32'(stat_cnt),   32'd0);
        chk({tag, "_hit"},   32'(stat_hit),   32'd0);
        chk({tag, "_xmin"},  32'(stat_xmin),  32'd0);
        chk({tag, "_xmax"},  32'(stat_xmax),  32'd0);
        chk({tag, "_ymin"},  32'(stat_ymin),  32'd0);
        chk({tag, "_ymax"},  32'(stat_ymax),  32'd0);
        chk({tag, "_err"},   32'(stat_err),   32'd0);
        chk({tag, "_fc"},    32'(frame_cnt),  32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && stat_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(stat_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("cnt",       32'(stat_cnt),  e.cnt);
                chk("hit",       32'(stat_hit),  e.hit);
                chk("err",       32'(stat_err),  e.err);
                chk("xmin",      32'(stat_xmin), e.xmin);
                chk("xmax",      32'(stat_xmax), e.xmax);
                chk("ymin",      32'(stat_ymin), e.ymin);
                chk("ymax",      32'(stat_ymax), e.ymax);
                chk("frame_cnt", 32'(frame_cnt), e.fc);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_vsync = 1'b0;
        in_href  = 1'b0;
        in_clken = 1'b0;
        in_bit   = 1'b0;
        m_active = 1'b0;
        m_frames = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Pixels before the first SOF are ignored; first SOF must not publish.
        drive_line(0, 4, 1'b0, 1'b1, -1);
        do_sof(1'b0);

        // Two edge pixels at (10,5) and (60,40).
        for (int y = 0; y <= 40; y++)
            drive_line(y, (y == 5) ? 11 : (y == 40) ? 61 : 1, 1'b0, 1'b0,
                       (y == 5) ? 10 : (y == 40) ? 60 : -1);
        do_sof(1'b0);

        // Full all-ones frame; 3072 pixels overflow an 11-bit counter.
        for (int y = 0; y < V; y++) drive_line(y, H, 1'b0, 1'b1, -1);
        do_sof(1'b0);

        // Edge-free frame.
        for (int y = 0; y < 4; y++) drive_line(y, 8, 1'b0, 1'b0, -1);
        do_sof(1'b0);

        // Over-long line: columns H..H+4 are geometry errors.
        drive_line(0, H + 5, 1'b0, 1'b1, -1);
        drive_line(1, 3, 1'b0, 1'b0, -1);
        do_sof(1'b0);

        // One line too many: line V is a geometry error.
        for (int y = 0; y <= V; y++) drive_line(y, 1, 1'b0, 1'b1, -1);
        do_sof(1'b0);

        // clken gaps within href; the edge sits at pixel index 5.
        drive_line(0, 8, 1'b1, 1'b0, 5);
        drive_line(1, 2, 1'b0, 1'b0, -1);
        do_sof(1'b1);

        // A pixel offered with vsync high must not appear at (0,0) here.
        drive_line(0, 4, 1'b0, 1'b0, -1);
        drive_line(1, 4, 1'b0, 1'b0, -1);
        drive_line(2, 6, 1'b0, 1'b0, 3);
        do_sof(1'b0);

        // Mid-frame reset: partial frame is dropped and frame_cnt restarts.
        drive_line(0, 10, 1'b0, 1'b1, -1);
        in_href  = 1'b1;
        in_clken = 1'b1;
        in_bit   = 1'b1;
        repeat (2) @(posedge clk) #1;
        rst_n = 1'b0;
        #2;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk) #1;
        in_href  = 1'b0;
        in_clken = 1'b0;
        in_bit   = 1'b0;
        m_active = 1'b0;
        m_frames = 0;
        model_clear();
        rst_n = 1'b1;
        @(posedge clk) #1;
        drive_line(0, 5, 1'b0, 1'b1, -1);
        do_sof(1'b0);
        drive_line(0, 3, 1'b0, 1'b0, 1);
        drive_line(1, 3, 1'b0, 1'b0, -1);
        do_sof(1'b0);

        repeat (5) @(posedge clk) #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
